awg_reg_bank: RTL and testbench
===============================

Name: awg_reg_bank

Overview:
- Register bank for the AWG control path. It sits directly downstream of the local-bus-to-register-bus bridge and consumes its single-cycle WREN/RDEN strobes.
- Decodes a 256-byte window into control, command, status and interrupt registers.
- Returns read data with fixed 1-cycle latency and an RVLD pulse.
- Drives control levels, self-clearing command pulses and a level interrupt to the waveform engine.

Parameters:
- BASE_ADDR, 32'h0000_0000, window base; only bits [31:8] are compared.
- VERSION, 32'h0001_0000, value returned at offset 0x00.
- WAVE_LEN_RST, 16'd1024, reset value of WAVE_LEN.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-high
- REG_WREN  in  1  write strobe, one cycle per access
- REG_WADR  in  32  write byte address
- REG_WDAT  in  32  write data
- REG_RDEN  in  1  read strobe, one cycle per access
- REG_RADR  in  32  read byte address
- REG_RDAT  out  32  read data
- REG_RVLD  out  1  read data valid pulse
- AWG_BUSY  in  1  engine busy level
- EVT_DONE  in  1  one-cycle done event
- EVT_UNDERRUN  in  1  one-cycle underrun event
- CTRL_ENABLE  out  1  engine enable level
- CTRL_LOOP  out  1  loop mode
- CTRL_CH_SEL  out  4  channel select
- WAVE_LEN  out  16  waveform length in samples
- CMD_START  out  1  start pulse
- CMD_STOP  out  1  stop pulse
- IRQ  out  1  interrupt level

Behaviour:
- Clock and reset: one clock CLK; RST is synchronous, active-high.
- Reset values:
  - All outputs 0, except WAVE_LEN = WAVE_LEN_RST.
  - IRQ_STAT, IRQ_EN, SCRATCH and CTRL fields are 0.
- Decode:
  - A hit requires ADR[31:8] == BASE_ADDR[31:8].
  - The register is selected by offset ADR[7:2]; ADR[1:0] are ignored.
  - Writes that miss the window, or hit an unmapped offset or an RO register, are ignored.
  - Reads that miss the window or hit an unmapped offset return 32'h0 but still produce RVLD.
- Register map (byte offsets):
  - 0x00 VERSION (RO).
  - 0x04 CTRL (RW): [0] ENABLE, [1] LOOP, [7:4] CH_SEL; other bits read 0.
  - 0x08 CMD (WO, reads 0): [0] START, [1] STOP.
  - 0x0C STATUS (RO): [0] AWG_BUSY sampled live, [1] IRQ.
  - 0x10 IRQ_STAT (W1C): [0] DONE, [1] UNDERRUN.
  - 0x14 IRQ_EN (RW) [1:0].
  - 0x18 WAVE_LEN (RW) [15:0].
  - 0x1C SCRATCH (RW) [31:0].
- Write timing: a register updates on the clock edge where REG_WREN=1; the new value is visible on outputs the next cycle.
- CMD pulses:
  - Writing CMD with bit=1 gives a one-cycle pulse on CMD_START/CMD_STOP in the cycle after WREN.
  - Back-to-back writes give back-to-back pulses.
  - If START and STOP are written together, only STOP pulses.
- Read timing:
  - REG_RDEN in cycle N gives REG_RVLD=1 with REG_RDAT valid in cycle N+1.
  - RVLD is a one-cycle pulse.
  - REG_RDAT holds its last value when RVLD=0.
- Same-cycle WREN and RDEN to the same register: the read returns the pre-write value.
- IRQ_STAT:
  - A bit sets on its EVT_* pulse.
  - It clears on a write with 1 in that bit position; writing 0 has no effect.
  - If the event and the W1C clear hit the same bit in the same cycle, set wins.
  - Reading does not clear.
- IRQ: registered, equal to |(IRQ_STAT & IRQ_EN[1:0]); it lags an IRQ_STAT or IRQ_EN change by one cycle.
- Reset mid-operation: any pending RVLD or CMD pulse is dropped and no pulse is emitted after RST deasserts.
- No back-pressure exists: a new strobe can arrive every cycle and must be served every cycle.

Decomposition:
- Package awg_reg_pkg holds:
  - Offset localparams (OFS_VERSION .. OFS_SCRATCH).
  - CTRL/CMD/IRQ bit-index localparams.
  - A packed struct typedef awg_ctrl_t with fields enable, loop, ch_sel.
- One sub-module, awg_w1c_bit: a sticky status bit with set input, W1C clear input and set-priority. It is instantiated twice.

Test Plan:
- Reset read: after reset, read 0x00/0x04/0x18 -> RDAT 32'h0001_0000 / 32'h0 / 32'h0000_0400; each RVLD exactly 1 cycle after RDEN.
- CTRL write/read: write 0x04 = 32'hFFFF_FFFF -> CTRL_ENABLE=1, CTRL_LOOP=1, CTRL_CH_SEL=4'hF next cycle; read back 32'h0000_00F3.
- Commands: write 0x08 = 1 -> single CMD_START pulse; write 0x08 = 3 -> CMD_STOP pulse only, CMD_START stays 0; a read of 0x08 returns 0.
- Interrupt flow:
  - Write IRQ_EN = 2'b01, pulse EVT_DONE -> IRQ_STAT=1; IRQ=1 the next cycle.
  - Pulse EVT_UNDERRUN -> IRQ_STAT=3 and IRQ stays 1.
  - Write IRQ_STAT = 1 -> IRQ_STAT=2, IRQ=0.
- Collision cases:
  - EVT_DONE in the same cycle as a W1C of bit 0 -> bit stays 1.
  - Same-cycle write 0x1C = 32'hA5A5_A5A5 and read 0x1C -> read returns the old value; the next read returns 32'hA5A5_A5A5.
- Decode and reset edge cases:
  - Read 0x40 or BASE_ADDR+0x100 -> RDAT 0, RVLD 1.
  - Write to 0x00 -> VERSION unchanged.
  - Assert RST the cycle after RDEN -> no RVLD is emitted.

Source files
------------

// File: rtl/awg_reg_bank_pkg.sv
// Shared register offsets, bit positions and CTRL layout for the AWG register bank.
package awg_reg_pkg;

    localparam logic [7:0] OFS_VERSION  = 8'h00;
    localparam logic [7:0] OFS_CTRL     = 8'h04;
    localparam logic [7:0] OFS_CMD      = 8'h08;
    localparam logic [7:0] OFS_STATUS   = 8'h0C;
    localparam logic [7:0] OFS_IRQ_STAT = 8'h10;
    localparam logic [7:0] OFS_IRQ_EN   = 8'h14;
    localparam logic [7:0] OFS_WAVE_LEN = 8'h18;
    localparam logic [7:0] OFS_SCRATCH  = 8'h1C;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_LOOP_BIT   = 1;
    localparam int CTRL_CH_LSB     = 4;
    localparam int CMD_START_BIT   = 0;
    localparam int CMD_STOP_BIT    = 1;
    localparam int IRQ_DONE_BIT    = 0;
    localparam int IRQ_UNDER_BIT   = 1;

    typedef struct packed {
        logic [3:0] ch_sel;
        logic       loop;
        logic       enable;
    } awg_ctrl_t;

    // Registers are word aligned; the word index is what the decoder compares.
    function automatic logic [5:0] word_idx(input logic [7:0] ofs);
        return ofs[7:2];
    endfunction

endpackage

// File: rtl/awg_reg_bank_if.sv
// Register bus as presented by the local-bus bridge: single-cycle write/read strobes, read data returned one cycle later with RVLD.
interface awg_reg_bank_if;
    logic        REG_WREN;
    logic [31:0] REG_WADR;
    logic [31:0] REG_WDAT;
    logic        REG_RDEN;
    logic [31:0] REG_RADR;
    logic [31:0] REG_RDAT;
    logic        REG_RVLD;

    modport master (
        output REG_WREN, REG_WADR, REG_WDAT, REG_RDEN, REG_RADR,
        input  REG_RDAT, REG_RVLD
    );

    modport slave (
        input  REG_WREN, REG_WADR, REG_WDAT, REG_RDEN, REG_RADR,
        output REG_RDAT, REG_RVLD
    );
endinterface

// File: rtl/awg_reg_bank_w1c_bit.sv
// Sticky status bit: set by an event, cleared by a write-one-to-clear; set wins on collision.
module awg_w1c_bit (
    input  logic CLK,
    input  logic RST,
    input  logic set_i,
    input  logic clr_i,
    output logic q_o
);
    logic q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) q_d = 1'b0;
        if (set_i) q_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) q_q <= 1'b0;
        else     q_q <= q_d;
    end

    assign q_o = q_q;
endmodule

// File: rtl/awg_reg_bank.sv
// AWG control register bank: decodes a 256-byte window into control, command, status and interrupt registers.
module awg_reg_bank
    import awg_reg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter logic [31:0] VERSION      = 32'h0001_0000,
    parameter logic [15:0] WAVE_LEN_RST = 16'd1024
) (
    input  logic              CLK,
    input  logic              RST,
    awg_reg_bank_if.slave     bus,
    input  logic              AWG_BUSY,
    input  logic              EVT_DONE,
    input  logic              EVT_UNDERRUN,
    output logic              CTRL_ENABLE,
    output logic              CTRL_LOOP,
    output logic [3:0]        CTRL_CH_SEL,
    output logic [15:0]       WAVE_LEN,
    output logic              CMD_START,
    output logic              CMD_STOP,
    output logic              IRQ
);
    awg_ctrl_t   ctrl_q, ctrl_d;
    logic [1:0]  irq_en_q, irq_en_d;
    logic [15:0] wave_len_q, wave_len_d;
    logic [31:0] scratch_q, scratch_d;
    logic        start_q, start_d, stop_q, stop_d;
    logic        irq_q, irq_d;
    logic [31:0] rdat_q, rdat_d;
    logic        rvld_q;
    logic [1:0]  irq_stat;

    logic       w_hit, r_hit;
    logic [5:0] w_idx, r_idx;
    logic       we_cmd, we_irq_stat;
    logic [31:0] rd_mux;
    logic       sig_unused;

    assign w_hit = bus.REG_WREN && (bus.REG_WADR[31:8] == BASE_ADDR[31:8]);
    assign r_hit = bus.REG_RADR[31:8] == BASE_ADDR[31:8];
    assign w_idx = bus.REG_WADR[7:2];
    assign r_idx = bus.REG_RADR[7:2];
    assign sig_unused = ^{bus.REG_WADR[1:0], bus.REG_RADR[1:0]};

    assign we_cmd      = w_hit && (w_idx == word_idx(OFS_CMD));
    assign we_irq_stat = w_hit && (w_idx == word_idx(OFS_IRQ_STAT));

    always_comb begin
        ctrl_d     = ctrl_q;
        irq_en_d   = irq_en_q;
        wave_len_d = wave_len_q;
        scratch_d  = scratch_q;
        if (w_hit) begin
            case (w_idx)
                word_idx(OFS_CTRL): begin
                    ctrl_d.enable = bus.REG_WDAT[CTRL_ENABLE_BIT];
                    ctrl_d.loop   = bus.REG_WDAT[CTRL_LOOP_BIT];
                    ctrl_d.ch_sel = bus.REG_WDAT[CTRL_CH_LSB +: 4];
                end
                word_idx(OFS_IRQ_EN):   irq_en_d   = bus.REG_WDAT[1:0];
                word_idx(OFS_WAVE_LEN): wave_len_d = bus.REG_WDAT[15:0];
                word_idx(OFS_SCRATCH):  scratch_d  = bus.REG_WDAT;
                default: ;
            endcase
        end
    end

    // STOP takes precedence when both command bits are written together.
    assign stop_d  = we_cmd && bus.REG_WDAT[CMD_STOP_BIT];
    assign start_d = we_cmd && bus.REG_WDAT[CMD_START_BIT] && !bus.REG_WDAT[CMD_STOP_BIT];

    awg_w1c_bit u_done (
        .CLK   (CLK),
        .RST   (RST),
        .set_i (EVT_DONE),
        .clr_i (we_irq_stat && bus.REG_WDAT[IRQ_DONE_BIT]),
        .q_o   (irq_stat[IRQ_DONE_BIT])
    );

    awg_w1c_bit u_underrun (
        .CLK   (CLK),
        .RST   (RST),
        .set_i (EVT_UNDERRUN),
        .clr_i (we_irq_stat && bus.REG_WDAT[IRQ_UNDER_BIT]),
        .q_o   (irq_stat[IRQ_UNDER_BIT])
    );

    assign irq_d = |(irq_stat & irq_en_q);

    // Read mux sees register state before any same-cycle write lands.
    always_comb begin
        rd_mux = 32'h0;
        if (r_hit) begin
            case (r_idx)
                word_idx(OFS_VERSION):  rd_mux = VERSION;
                word_idx(OFS_CTRL):     rd_mux = {24'h0, ctrl_q.ch_sel, 2'b00, ctrl_q.loop, ctrl_q.enable};
                word_idx(OFS_STATUS):   rd_mux = {30'h0, irq_q, AWG_BUSY};
                word_idx(OFS_IRQ_STAT): rd_mux = {30'h0, irq_stat};
                word_idx(OFS_IRQ_EN):   rd_mux = {30'h0, irq_en_q};
                word_idx(OFS_WAVE_LEN): rd_mux = {16'h0, wave_len_q};
                word_idx(OFS_SCRATCH):  rd_mux = scratch_q;
                default:                rd_mux = 32'h0;
            endcase
        end
    end

    assign rdat_d = bus.REG_RDEN ? rd_mux : rdat_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ctrl_q     <= '0;
            irq_en_q   <= 2'b00;
            wave_len_q <= WAVE_LEN_RST;
            scratch_q  <= 32'h0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            irq_q      <= 1'b0;
            rdat_q     <= 32'h0;
            rvld_q     <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            irq_en_q   <= irq_en_d;
            wave_len_q <= wave_len_d;
            scratch_q  <= scratch_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            irq_q      <= irq_d;
            rdat_q     <= rdat_d;
            rvld_q     <= bus.REG_RDEN;
        end
    end

    // Pulses already registered are masked while RST is high so a reset drops them.
    assign bus.REG_RVLD = rvld_q && !RST;
    assign bus.REG_RDAT = rdat_q;
    assign CMD_START    = start_q && !RST;
    assign CMD_STOP     = stop_q && !RST;
    assign CTRL_ENABLE  = ctrl_q.enable;
    assign CTRL_LOOP    = ctrl_q.loop;
    assign CTRL_CH_SEL  = ctrl_q.ch_sel;
    assign WAVE_LEN     = wave_len_q;
    assign IRQ          = irq_q;
endmodule

// File: tb/tb_awg_reg_bank.sv
// Bench for awg_reg_bank: directed register accesses, read data checked by a monitor against an expected queue.
module tb_awg_reg_bank;
    logic        CLK = 1'b0;
    logic        RST;
    logic        AWG_BUSY, EVT_DONE, EVT_UNDERRUN;
    logic        CTRL_ENABLE, CTRL_LOOP, CMD_START, CMD_STOP, IRQ;
    logic [3:0]  CTRL_CH_SEL;
    logic [15:0] WAVE_LEN;

    logic [31:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic        rden_prev;

    awg_reg_bank_if bus();

    awg_reg_bank dut (
        .CLK          (CLK),
        .RST          (RST),
        .bus          (bus),
        .AWG_BUSY     (AWG_BUSY),
        .EVT_DONE     (EVT_DONE),
        .EVT_UNDERRUN (EVT_UNDERRUN),
        .CTRL_ENABLE  (CTRL_ENABLE),
        .CTRL_LOOP    (CTRL_LOOP),
        .CTRL_CH_SEL  (CTRL_CH_SEL),
        .WAVE_LEN     (WAVE_LEN),
        .CMD_START    (CMD_START),
        .CMD_STOP     (CMD_STOP),
        .IRQ          (IRQ)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.REG_WREN = 1'b1;
        bus.REG_WADR = a;
        bus.REG_WDAT = d;
        tick();
        bus.REG_WREN = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp);
        bus.REG_RDEN = 1'b1;
        bus.REG_RADR = a;
        exp_q.push_back(exp);
        tick();
        bus.REG_RDEN = 1'b0;
    endtask

    // Monitor: RVLD must follow RDEN by exactly one cycle; data popped from exp_q.
    initial begin
        logic exp_v;
        rden_prev = 1'b0;
        forever begin
            @(negedge CLK);
            exp_v = rden_prev && (RST !== 1'b1);
            if (exp_v || bus.REG_RVLD) begin
                chk("rvld_timing", {31'h0, bus.REG_RVLD}, {31'h0, exp_v});
                if (bus.REG_RVLD === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL rdat_unexpected: got %08h with no read outstanding", bus.REG_RDAT);
                    end else begin
                        chk("rdat", bus.REG_RDAT, exp_q.pop_front());
                    end
                end
            end
            rden_prev = (bus.REG_RDEN === 1'b1);
        end
    end

    initial begin
        RST = 1'b1;
        AWG_BUSY = 1'b0; EVT_DONE = 1'b0; EVT_UNDERRUN = 1'b0;
        bus.REG_WREN = 1'b0; bus.REG_WADR = '0; bus.REG_WDAT = '0;
        bus.REG_RDEN = 1'b0; bus.REG_RADR = '0;
        repeat (3) tick();
        RST = 1'b0;

        chk("rst_ctrl", {24'h0, CTRL_CH_SEL, 2'b00, CTRL_LOOP, CTRL_ENABLE}, 32'h0);
        chk("rst_wave_len", {16'h0, WAVE_LEN}, 32'h0000_0400);
        chk("rst_cmd_irq", {29'h0, CMD_START, CMD_STOP, IRQ}, 32'h0);

        rd(32'h00, 32'h0001_0000);
        rd(32'h04, 32'h0);
        rd(32'h18, 32'h0000_0400);
        tick();
        chk("rdat_hold", bus.REG_RDAT, 32'h0000_0400);

        wr(32'h04, 32'hFFFF_FFFF);
        chk("ctrl_out", {24'h0, CTRL_CH_SEL, 2'b00, CTRL_LOOP, CTRL_ENABLE}, 32'h0000_00F3);
        rd(32'h04, 32'h0000_00F3);
        wr(32'h18, 32'h1234_0200);
        chk("wave_len_out", {16'h0, WAVE_LEN}, 32'h0000_0200);
        rd(32'h1A, 32'h0000_0200);

        wr(32'h08, 32'h1);
        chk("start_pulse", {30'h0, CMD_START, CMD_STOP}, 32'h2);
        tick();
        chk("start_one_cycle", {30'h0, CMD_START, CMD_STOP}, 32'h0);
        wr(32'h08, 32'h3);
        chk("stop_only", {30'h0, CMD_START, CMD_STOP}, 32'h1);
        wr(32'h08, 32'h1);
        chk("b2b_start", {30'h0, CMD_START, CMD_STOP}, 32'h2);
        wr(32'h08, 32'h1);
        chk("b2b_start2", {30'h0, CMD_START, CMD_STOP}, 32'h2);
        rd(32'h08, 32'h0);

        AWG_BUSY = 1'b1;
        rd(32'h0C, 32'h1);
        AWG_BUSY = 1'b0;

        wr(32'h14, 32'h1);
        EVT_DONE = 1'b1;
        tick();
        EVT_DONE = 1'b0;
        chk("irq_lag", {31'h0, IRQ}, 32'h0);
        tick();
        chk("irq_set", {31'h0, IRQ}, 32'h1);
        rd(32'h10, 32'h1);
        EVT_UNDERRUN = 1'b1;
        tick();
        EVT_UNDERRUN = 1'b0;
        rd(32'h10, 32'h3);
        chk("irq_stays", {31'h0, IRQ}, 32'h1);
        rd(32'h0C, 32'h2);
        wr(32'h10, 32'h1);
        tick();
        chk("irq_cleared", {31'h0, IRQ}, 32'h0);
        rd(32'h10, 32'h2);

        EVT_DONE = 1'b1;
        wr(32'h10, 32'h1);
        EVT_DONE = 1'b0;
        rd(32'h10, 32'h3);
        wr(32'h10, 32'h3);
        rd(32'h10, 32'h0);

        bus.REG_WREN = 1'b1; bus.REG_WADR = 32'h1C; bus.REG_WDAT = 32'hA5A5_A5A5;
        bus.REG_RDEN = 1'b1; bus.REG_RADR = 32'h1C;
        exp_q.push_back(32'h0);
        tick();
        bus.REG_WREN = 1'b0; bus.REG_RDEN = 1'b0;
        rd(32'h1C, 32'hA5A5_A5A5);

        rd(32'h40, 32'h0);
        rd(32'h100, 32'h0);
        wr(32'h104, 32'h0);
        chk("miss_write", {31'h0, CTRL_ENABLE}, 32'h1);
        wr(32'h00, 32'hDEAD_BEEF);
        rd(32'h00, 32'h0001_0000);

        bus.REG_RDEN = 1'b1; bus.REG_RADR = 32'h00;
        bus.REG_WREN = 1'b1; bus.REG_WADR = 32'h08; bus.REG_WDAT = 32'h1;
        tick();
        bus.REG_RDEN = 1'b0; bus.REG_WREN = 1'b0;
        RST = 1'b1;
        #2;
        chk("rst_drop_start", {31'h0, CMD_START}, 32'h0);
        tick();
        RST = 1'b0;
        chk("post_rst_wave_len", {16'h0, WAVE_LEN}, 32'h0000_0400);
        chk("post_rst_ctrl", {31'h0, CTRL_ENABLE}, 32'h0);
        tick();
        chk("post_rst_no_pulse", {30'h0, CMD_START, bus.REG_RVLD}, 32'h0);
        rd(32'h1C, 32'h0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL read_timeout: %0d reads outstanding, expected 0", exp_q.size());
        end
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
